// File: rtl/montgomery_product_if.sv
// Request/response bundle for montgomery_product.
// The master side drives start and the operands. The slave side returns the
// result and the status flags.
interface montgomery_product_if;
  logic         start;
  logic [255:0] N;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] m;
  logic         busy;
  logic         finish;

  modport master (output start, N, a, b, input  m, busy, finish);
  modport slave  (input  start, N, a, b, output m, busy, finish);
endinterface

// File: rtl/montgomery_product.sv
// Bit-serial Montgomery product m = a*b*2^-256 mod N.
// The core does one radix-2 step per cycle, so a job takes a fixed number of
// cycles that does not depend on the data.
//
// Build option MONTGOMERY_FINAL_SUB_EN:
//   defined   - a FINAL state runs the conditional subtraction, so m < N.
//               finish comes 258 edges after the start edge.
//   undefined - FINAL is skipped and m = t, which is congruent but lies in
//               [0, 2N). This mode needs N < 2^255. finish comes 257 edges
//               after the start edge.
module montgomery_product (
  input  logic               clk,
  input  logic               rst_n,
  montgomery_product_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef MONTGOMERY_FINAL_SUB_EN
    FINAL = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] n_r, a_r, b_r;
  logic [257:0] t_q, t_next;
  logic [8:0]   cnt_q;
  logic [255:0] m_q;
  logic         calc_last;

  // Iterations run while cnt is 0..255. At cnt == 256 CALC spends one idle
  // cycle before it leaves, which fixes the overall latency.
  assign calc_last = (cnt_q == 9'd256);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = CALC;
`ifdef MONTGOMERY_FINAL_SUB_EN
      CALC:  if (calc_last) state_d = FINAL;
      FINAL: state_d = DONE;
`else
      CALC:  if (calc_last) state_d = DONE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs. busy starts one cycle after the accepting edge and drops
  // when finish rises.
  always_comb begin
    bus.busy   = (state_q == CALC && cnt_q != 9'd0)
`ifdef MONTGOMERY_FINAL_SUB_EN
                 || (state_q == FINAL)
`endif
                 ;
    bus.finish = (state_q == DONE);
    bus.m      = m_q;
  end

  // One Montgomery step: add b when the current multiplier bit is set, add N
  // when the sum is odd so it becomes even, then halve. With t < 2N on entry,
  // every intermediate value stays below 4N < 2^258.
  always_comb begin
    logic [257:0] t1, t2;
    t1     = t_q + (a_r[cnt_q[7:0]] ? {2'b00, b_r} : 258'd0);
    t2     = t1  + (t1[0]           ? {2'b00, n_r} : 258'd0);
    t_next = t2 >> 1;
  end

`ifdef MONTGOMERY_FINAL_SUB_EN
  logic         t_ge_n;
  logic [255:0] m_fin;
  // Final reduction. Because t < 2N, a single subtraction is enough, and the
  // low 256 bits of the subtraction are exact.
  always_comb begin
    t_ge_n = (t_q >= {2'b00, n_r});
    m_fin  = t_ge_n ? (t_q[255:0] - n_r) : t_q[255:0];
  end
`endif

  // Datapath registers: latch operands on accept, iterate in CALC, load the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      t_q   <= '0;
      cnt_q <= '0;
      m_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          n_r   <= bus.N;
          a_r   <= bus.a;
          b_r   <= bus.b;
          t_q   <= '0;
          cnt_q <= '0;
        end
        CALC: if (!calc_last) begin
          t_q   <= t_next;
          cnt_q <= cnt_q + 9'd1;
        end
`ifndef MONTGOMERY_FINAL_SUB_EN
        else m_q <= t_q[255:0];
`endif
`ifdef MONTGOMERY_FINAL_SUB_EN
        FINAL: m_q <= m_fin;
`endif
        default: ;
      endcase
    end
  end

endmodule
